// File: rtl/spi_master.sv
// spi_master -- single-clock SPI master framing host command words onto ss_n/MOSI
// and capturing 8-bit read data from MISO for read-data (opcode 2'b11) frames.
//
// Frame: START (direction bit) + SHIFT (10 bits MSB-first); read-data frames add
// WAIT (RD_WAIT turnaround cycles) and RECV (8 MISO samples). Every frame is
// followed by GAP cycles of ss_n high before the next command is accepted.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   cmd_data[9:0]        {opcode[1:0], payload[7:0]}
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   rd_data[7:0]         last captured MISO byte, held until next rd_valid
//   rd_valid             one-cycle pulse with new rd_data
//   busy                 frame in progress
//   cmd_err              one-cycle pulse, rejected read-data command
//   ss_n, MOSI, MISO     SPI pins (ss_n/MOSI registered)
//
// Build option: define SPI_MASTER_CMD_CHECK_EN to reject a read-data command
// (opcode 11) that is not preceded by a read-address command (opcode 10).
// Without it cmd_err is tied low and every opcode is framed.
module spi_master #(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       cmd_err,
    output logic       ss_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_WAIT, S_RECV, S_GAP} state_t;

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [9:0] sh, sh_d;        // outgoing word, shifted left as bits go out
    logic       rd_op, rd_op_d;  // current frame is a read-data frame
    logic [7:0] sr, sr_d;        // incoming MISO bits
    logic [7:0] rd_data_d;
    logic       rd_valid_d, ss_n_d, mosi_d;

`ifdef SPI_MASTER_CMD_CHECK_EN
    logic rd_addr_seen, rd_addr_seen_d;
    logic cmd_err_d;
`else
    assign cmd_err = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            sh       <= 10'd0;
            rd_op    <= 1'b0;
            sr       <= 8'd0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            ss_n     <= 1'b1;
            MOSI     <= 1'b0;
`ifdef SPI_MASTER_CMD_CHECK_EN
            rd_addr_seen <= 1'b0;
            cmd_err      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sh       <= sh_d;
            rd_op    <= rd_op_d;
            sr       <= sr_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            ss_n     <= ss_n_d;
            MOSI     <= mosi_d;
`ifdef SPI_MASTER_CMD_CHECK_EN
            rd_addr_seen <= rd_addr_seen_d;
            cmd_err      <= cmd_err_d;
`endif
        end
    end

    // Next-state logic computes the registered pin values for the coming cycle,
    // so ss_n/MOSI change exactly on the edge that enters each state.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        sh_d       = sh;
        rd_op_d    = rd_op;
        sr_d       = sr;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        ss_n_d     = ss_n;
        mosi_d     = MOSI;
`ifdef SPI_MASTER_CMD_CHECK_EN
        rd_addr_seen_d = rd_addr_seen;
        cmd_err_d      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    sh_d    = cmd_data;
                    rd_op_d = (cmd_data[9:8] == 2'b11);
                    state_d = S_START;
                    ss_n_d  = 1'b0;
                    mosi_d  = cmd_data[9];
`ifdef SPI_MASTER_CMD_CHECK_EN
                    if (cmd_data[9:8] == 2'b10) rd_addr_seen_d = 1'b1;
                    if (cmd_data[9:8] == 2'b11) begin
                        rd_addr_seen_d = 1'b0;
                        if (!rd_addr_seen) begin
                            // consumed but not framed: pins stay idle
                            state_d   = S_GAP;
                            cnt_d     = 8'd0;
                            ss_n_d    = 1'b1;
                            mosi_d    = 1'b0;
                            cmd_err_d = 1'b1;
                        end
                    end
`endif
                end
            end
            S_START: begin
                // direction bit is cmd[9], so the first SHIFT bit repeats it
                state_d = S_SHIFT;
                cnt_d   = 8'd0;
                mosi_d  = sh[9];
                sh_d    = {sh[8:0], 1'b0};
            end
            S_SHIFT: begin
                if (cnt == 8'd9) begin
                    cnt_d  = 8'd0;
                    mosi_d = 1'b0;
                    if (rd_op) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_GAP;
                        ss_n_d  = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt + 8'd1;
                    mosi_d = sh[9];
                    sh_d   = {sh[8:0], 1'b0};
                end
            end
            S_WAIT: begin
                if (cnt == 8'(RD_WAIT - 1)) begin
                    state_d = S_RECV;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            S_RECV: begin
                sr_d = {sr[6:0], MISO};
                if (cnt == 8'd7) begin
                    rd_data_d  = {sr[6:0], MISO};
                    rd_valid_d = 1'b1;
                    ss_n_d     = 1'b1;
                    state_d    = S_GAP;
                    cnt_d      = 8'd0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt == 8'(GAP - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master: reset, write frame, read-data frame,
// back-to-back commands, mid-frame reset, and the optional command check.
module tb_spi_master;

    localparam int RW = 2;
    localparam int GP = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] cmd_data = 10'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       cmd_err;
    logic       ss_n;
    logic       MOSI;
    logic       MISO = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    spi_master #(.RD_WAIT(RW), .GAP(GP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .cmd_err(cmd_err), .ss_n(ss_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Present a command and return right after its handshake edge; bounded wait.
    task automatic send(input logic [9:0] c, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = c;
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ss_n !== 1'b1)      begin bad++; $display("FAIL reset_ss_n got=%b exp=1", ss_n); end
        total++; if (MOSI !== 1'b0)      begin bad++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 8'h00)  begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        total++; if (cmd_err !== 1'b0)   begin bad++; $display("FAIL reset_cmd_err got=%b exp=0", cmd_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        bit ok;
        logic [10:0] obs;
        int lowc, rvc;
        logic hi11, busy0, rdy0;
        obs = '0; lowc = 0; rvc = 0; hi11 = 1'b0; busy0 = 1'b0; rdy0 = 1'b1;
        send(10'h0A5, ok);
        total++; if (!ok) begin bad++; $display("FAIL write_handshake got=timeout exp=ready"); end
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k < 11) obs[10-k] = MOSI;
            if (!ss_n) lowc++;
            if (rd_valid) rvc++;
            if (k == 0) begin busy0 = busy; rdy0 = cmd_ready; end
            if (k == 11) hi11 = ss_n;
        end
        total++; if (obs !== 11'b00010100101) begin bad++; $display("FAIL write_mosi got=%b exp=00010100101", obs); end
        total++; if (lowc != 11)   begin bad++; $display("FAIL write_ss_low got=%0d exp=11", lowc); end
        total++; if (hi11 !== 1'b1) begin bad++; $display("FAIL write_ss_high_T11 got=%b exp=1", hi11); end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL write_busy got=%b exp=1", busy0); end
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL write_ready_low got=%b exp=0", rdy0); end
        total++; if (rvc != 0)     begin bad++; $display("FAIL write_no_rd_valid got=%0d exp=0", rvc); end
    endtask

    task automatic test_read();
        bit ok;
        logic [7:0] pat, got;
        int lowc, rvc, rvk, mnz;
        logic ss_at_rv;
        pat = 8'hC3; got = 8'h00; lowc = 0; rvc = 0; rvk = -1; mnz = 0; ss_at_rv = 1'b0;
        send(10'h2F0, ok);
        total++; if (!ok) begin bad++; $display("FAIL read_addr_handshake got=timeout exp=ready"); end
        send(10'h300, ok);
        total++; if (!ok) begin bad++; $display("FAIL read_data_handshake got=timeout exp=ready"); end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            // MISO carries garbage 1s outside the receive window
            if (k >= 11 + RW && k <= 18 + RW) MISO = pat[7-(k-11-RW)];
            else MISO = 1'b1;
            if (!ss_n) lowc++;
            if (k >= 11 && k <= 18 + RW && MOSI !== 1'b0) mnz++;
            if (rd_valid) begin rvc++; rvk = k; got = rd_data; ss_at_rv = ss_n; end
        end
        MISO = 1'b0;
        total++; if (rvc != 1)       begin bad++; $display("FAIL read_rv_count got=%0d exp=1", rvc); end
        total++; if (rvk != 19 + RW) begin bad++; $display("FAIL read_rv_cycle got=%0d exp=%0d", rvk, 19 + RW); end
        total++; if (got !== 8'hC3)  begin bad++; $display("FAIL read_rd_data got=%h exp=c3", got); end
        total++; if (lowc != 19 + RW) begin bad++; $display("FAIL read_ss_low got=%0d exp=%0d", lowc, 19 + RW); end
        total++; if (ss_at_rv !== 1'b1) begin bad++; $display("FAIL read_ss_at_rv got=%b exp=1", ss_at_rv); end
        total++; if (mnz != 0)       begin bad++; $display("FAIL read_mosi_zero got=%0d exp=0", mnz); end
        total++; if (rd_data !== 8'hC3) begin bad++; $display("FAIL read_rd_data_hold got=%h exp=c3", rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] obs1, obs2;
        int t1, t2, hi;
        bit ok;
        obs1 = '0; obs2 = '0; t1 = 0; t2 = 0; hi = 0; ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 10'h055;
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready) begin ok = 1'b1; t1 = cyc + 1; break; end
            @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL b2b_first_handshake got=timeout exp=ready"); end
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            obs1[10-k] = MOSI;
            if (k == 0) cmd_data = 10'h1AA;
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ss_n) hi++;
            if (cmd_ready) begin ok = 1'b1; t2 = cyc + 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL b2b_second_handshake got=timeout exp=ready"); end
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            obs2[10-k] = MOSI;
            if (k == 0) cmd_valid = 1'b0;
        end
        total++; if (t2 - t1 != 12 + GP) begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", t2 - t1, 12 + GP); end
        // ss_n stays high through the GAP cycles plus the IDLE accept cycle
        total++; if (hi != GP + 1) begin bad++; $display("FAIL b2b_ss_high got=%0d exp=%0d", hi, GP + 1); end
        total++; if (obs1 !== 11'b00001010101) begin bad++; $display("FAIL b2b_mosi1 got=%b exp=00001010101", obs1); end
        total++; if (obs2 !== 11'b00110101010) begin bad++; $display("FAIL b2b_mosi2 got=%b exp=00110101010", obs2); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [10:0] obs;
        logic hi11;
        obs = '0; hi11 = 1'b0;
        send(10'h0A5, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_handshake got=timeout exp=ready"); end
        repeat (6) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (ss_n !== 1'b1) begin bad++; $display("FAIL rstmid_ss_n got=%b exp=1", ss_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (MOSI !== 1'b0) begin bad++; $display("FAIL rstmid_mosi got=%b exp=0", MOSI); end
        rst_n = 1'b1;
        send(10'h011, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_new_handshake got=timeout exp=ready"); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 11) obs[10-k] = MOSI;
            if (k == 11) hi11 = ss_n;
        end
        total++; if (obs !== 11'b00000010001) begin bad++; $display("FAIL rstmid_mosi_new got=%b exp=00000010001", obs); end
        total++; if (hi11 !== 1'b1) begin bad++; $display("FAIL rstmid_ss_end got=%b exp=1", hi11); end
    endtask

    task automatic test_cmd_check();
        bit ok;
        int errc, lowc, rvc;
        errc = 0; lowc = 0; rvc = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(10'h300, ok);
        total++; if (!ok) begin bad++; $display("FAIL chk_handshake got=timeout exp=ready"); end
`ifdef SPI_MASTER_CMD_CHECK_EN
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cmd_err) errc++;
            if (!ss_n) lowc++;
        end
        total++; if (errc != 1) begin bad++; $display("FAIL chk_err_pulse got=%0d exp=1", errc); end
        total++; if (lowc != 0) begin bad++; $display("FAIL chk_ss_idle got=%0d exp=0", lowc); end
        send(10'h2AA, ok);
        total++; if (!ok) begin bad++; $display("FAIL chk_addr_handshake got=timeout exp=ready"); end
        send(10'h300, ok);
        total++; if (!ok) begin bad++; $display("FAIL chk_data_handshake got=timeout exp=ready"); end
        errc = 0; lowc = 0;
`endif
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cmd_err) errc++;
            if (!ss_n) lowc++;
            if (rd_valid) rvc++;
        end
        total++; if (errc != 0)      begin bad++; $display("FAIL chk_no_err got=%0d exp=0", errc); end
        total++; if (lowc != 19 + RW) begin bad++; $display("FAIL chk_read_ss_low got=%0d exp=%0d", lowc, 19 + RW); end
        total++; if (rvc != 1)       begin bad++; $display("FAIL chk_read_rv got=%0d exp=1", rvc); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_cmd_check();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
